// File: rtl/mem_responder_if.sv
// mem_responder_if: processor-to-memory request/response bus
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rdy;
    logic                  err;

    modport master (output addr, data_in, read, write, input data_out, rdy, err);
    modport slave  (input addr, data_in, read, write, output data_out, rdy, err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM window with programmable read latency and RDY/ERR strobes
module mem_responder #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 26,
    parameter int                    DEPTH_LOG2   = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 2
) (
    input logic            clk,
    input logic            rst_n,
    mem_responder_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_DONE = 2'd2;
    localparam logic [1:0] WR_DONE = 2'd3;
    localparam logic [3:0] CNT_INIT = READ_LATENCY > 1 ? 4'(READ_LATENCY - 2) : 4'd0;

    logic [1:0]            state;
    logic                  armed;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] lat_off;
    logic                  lat_oor;
    logic [DATA_WIDTH-1:0] ram [2**DEPTH_LOG2];

    logic [ADDR_WIDTH-1:0] diff;
    logic [DEPTH_LOG2-1:0] off, rd_off;
    logic                  in_win, go, no_req, acc_rd, acc_wr, both, to_rd_done, rd_oor;

    assign diff       = bus.addr - BASE_ADDR;
    assign in_win     = bus.addr >= BASE_ADDR && diff[ADDR_WIDTH-1:DEPTH_LOG2] == '0;
    assign off        = diff[DEPTH_LOG2-1:0];
    assign go         = state == IDLE && armed;
    assign no_req     = !bus.read && !bus.write;
    assign acc_rd     = go && bus.read && !bus.write;
    assign acc_wr     = go && bus.write && !bus.read;
    assign both       = go && bus.read && bus.write;
    assign to_rd_done = (acc_rd && READ_LATENCY == 1) || (state == RD_WAIT && cnt == 4'd0);
    // With single-cycle latency the read completes on the accept edge, so use the live address
    assign rd_off     = state == IDLE ? off : lat_off;
    assign rd_oor     = state == IDLE ? !in_win : lat_oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            armed        <= 1'b1;
            cnt          <= '0;
            lat_off      <= '0;
            lat_oor      <= 1'b0;
            bus.data_out <= '0;
            bus.rdy      <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            armed   <= no_req || (armed && state != IDLE);
            bus.rdy <= to_rd_done || acc_wr;
            bus.err <= both || (to_rd_done && rd_oor) || (acc_wr && !in_win);
            cnt     <= acc_rd ? CNT_INIT : (state == RD_WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            state   <= to_rd_done ? RD_DONE :
                       acc_wr ? WR_DONE :
                       acc_rd ? RD_WAIT :
                       (state == RD_DONE || state == WR_DONE) ? IDLE : state;
            if (acc_rd) begin
                lat_off <= off;
                lat_oor <= !in_win;
            end
            if (to_rd_done)
                bus.data_out <= rd_oor ? '0 : ram[rd_off];
        end
    end

    // Writes are blocked while reset is held so an aborted access cannot commit
    always_ff @(posedge clk) begin
        if (rst_n && acc_wr && in_win)
            ram[off] <= bus.data_in;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against an array model
module tb_mem_responder;
    localparam int LAT   = 2;
    localparam int WORDS = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pulses;

    logic [31:0] model [WORDS];
    bit          valid [WORDS];
    logic [31:0] last_rd = '0;

    mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(26)) bus ();

    mem_responder #(.READ_LATENCY(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [25:0] a, input logic [31:0] d);
        bus.addr = a; bus.data_in = d; bus.write = 1'b1;
        @(posedge clk); #1;
        chk("wr_rdy", bus.rdy, 1);
        chk("wr_err", bus.err, a >= WORDS);
        chk("wr_dout_hold", bus.data_out, last_rd);
        if (a < WORDS) begin
            model[a[9:0]] = d;
            valid[a[9:0]] = 1'b1;
        end
        bus.write = 1'b0;
        @(posedge clk); #1;
        chk("wr_rdy_end", bus.rdy, 0);
    endtask

    task automatic do_read(input logic [25:0] a);
        logic [31:0] exp;
        exp = a >= WORDS ? 32'h0 : model[a[9:0]];
        bus.addr = a; bus.read = 1'b1;
        @(posedge clk);
        for (int k = 1; k < LAT; k++) begin
            #1 chk("rd_early", bus.rdy, 0);
            bus.addr = ~a;
            @(posedge clk);
        end
        #1;
        chk("rd_rdy", bus.rdy, 1);
        chk("rd_err", bus.err, a >= WORDS);
        chk("rd_data", bus.data_out, exp);
        last_rd = exp;
        bus.read = 1'b0;
        @(posedge clk); #1;
        chk("rd_rdy_end", bus.rdy, 0);
        chk("rd_dout_hold", bus.data_out, exp);
    endtask

    initial begin
        logic [25:0] a;
        bus.addr = '0; bus.data_in = '0; bus.read = 1'b0; bus.write = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout", bus.data_out, 0);
        chk("rst_rdy", bus.rdy, 0);
        chk("rst_err", bus.err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_write(26'h10, 32'hDEADBEEF);
        do_read(26'h10);
        do_write(26'h0, $urandom);

        bus.addr = 26'h10; bus.read = 1'b1; pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.rdy) pulses++;
        end
        chk("hold_pulses", pulses, 1);
        bus.read = 1'b0;
        @(posedge clk); #1;
        bus.read = 1'b1; pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.rdy) pulses++;
        end
        chk("rearm_pulses", pulses, 1);
        bus.read = 1'b0;
        @(posedge clk); #1;

        bus.addr = 26'h10; bus.data_in = 32'h12345678; bus.read = 1'b1; bus.write = 1'b1;
        @(posedge clk); #1;
        chk("both_err", bus.err, 1);
        chk("both_rdy", bus.rdy, 0);
        @(posedge clk); #1;
        chk("both_err_end", bus.err, 0);
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.rdy || bus.err) pulses++;
        end
        chk("both_quiet", pulses, 0);
        bus.read = 1'b0; bus.write = 1'b0;
        @(posedge clk); #1;
        do_read(26'h10);

        do_read(26'h400);
        do_write(26'h400, 32'hCAFEF00D);
        do_read(26'h0);

        for (int i = 0; i < 40; i++) begin
            a = 26'($urandom_range(0, 1151));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom);
            end else begin
                if (a < WORDS && !valid[a[9:0]]) a = 26'h10;
                do_read(a);
            end
        end

        do_write(26'h10, 32'hDEADBEEF);
        do_read(26'h10);
        bus.addr = 26'h10; bus.read = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", bus.data_out, 0);
        chk("arst_rdy", bus.rdy, 0);
        chk("arst_err", bus.err, 0);
        last_rd = '0;
        bus.read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.rdy) pulses++;
        end
        chk("arst_no_rdy", pulses, 0);
        do_read(26'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
